mlp_trainer: RTL and testbench

Parametrised single-hidden-layer perceptron with on-chip output-layer training. It generalises the fixed two-hidden-neuron, four-input forward/backprop datapath to N_IN inputs and N_HID ReLU hidden neurons, using one time-shared MAC. It also adds a host weight read/write port, a registered error output and a real saturating weight update. It sits between the input pins/top-level sequencer and uo_out, replacing the separate state machine, hidden-neuron, output-neuron and backprop instances.

---
 rtl/mlp_pkg.sv | 63 ++++++
 rtl/mlp_trainer_if.sv | 34 +++
 rtl/mlp_mac.sv | 34 +++
 rtl/mlp_trainer.sv | 211 +++++++++++++++++++++
 tb/tb_mlp_trainer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared types and helper arithmetic for the perceptron trainer.
package mlp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD_HID,
    S_FWD_OUT,
    S_ERR,
    S_UPD,
    S_DONE
  } state_e;

  localparam int N_IN_DEF     = 4;
  localparam int N_HID_DEF    = 2;
  localparam int X_W_DEF      = 4;
  localparam int W_W_DEF      = 8;
  localparam int H_W_DEF      = 10;
  localparam int ACC_W_DEF    = 24;
  localparam int LR_SHIFT_DEF = 4;

  // Wide signed working type for saturation helpers; every datapath width
  // used here stays well below 64 bits.
  typedef logic signed [63:0] wide_t;

  // Address map: hidden weights w[j][i] first (j-major), then output weights v[j].
  function automatic int nw_of(input int n_in, input int n_hid);
    return n_hid * n_in + n_hid;
  endfunction

  function automatic int vbase_of(input int n_in, input int n_hid);
    return n_hid * n_in;
  endfunction

  // Power-on weight values: w[j][i] = i+1, v[j] = j+1.
  function automatic int def_w(input int i);
    return i + 1;
  endfunction

  function automatic int def_v(input int j);
    return j + 1;
  endfunction

  // Clamp a value to the signed range of the given width.
  function automatic wide_t sat_signed(input wide_t a, input int width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (a > hi) return hi;
    if (a < lo) return lo;
    return a;
  endfunction

  // ReLU followed by clamping to the unsigned range of the given width.
  function automatic wide_t relu_sat(input wide_t a, input int width);
    wide_t hi;
    hi = (wide_t'(1) <<< width) - wide_t'(1);
    if (a < wide_t'(0)) return wide_t'(0);
    if (a > hi) return hi;
    return a;
  endfunction

endpackage

// File: rtl/mlp_trainer_if.sv
// Host-facing bus of the perceptron trainer: pass control, data and weight port.
interface mlp_trainer_if
  import mlp_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_HID = N_HID_DEF,
  parameter int X_W   = X_W_DEF,
  parameter int W_W   = W_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int AW    = $clog2(N_HID * N_IN + N_HID)
);
  logic                    start_i;
  logic                    train_i;
  logic [N_IN*X_W-1:0]     x_i;
  logic [ACC_W-1:0]        target_i;
  logic                    w_wr_en_i;
  logic [AW-1:0]           w_addr_i;
  logic [W_W-1:0]          w_wr_data_i;
  logic [W_W-1:0]          w_rd_data_o;
  logic                    busy_o;
  logic                    done_o;
  logic [ACC_W-1:0]        y_o;
  logic [ACC_W-1:0]        err_o;

  modport slave (
    input  start_i, train_i, x_i, target_i, w_wr_en_i, w_addr_i, w_wr_data_i,
    output w_rd_data_o, busy_o, done_o, y_o, err_o
  );

  modport master (
    output start_i, train_i, x_i, target_i, w_wr_en_i, w_addr_i, w_wr_data_i,
    input  w_rd_data_o, busy_o, done_o, y_o, err_o
  );
endinterface

// File: rtl/mlp_mac.sv
// Time-shared signed multiply-accumulate. sum_o is the running sum including
// the current product, so callers can capture a finished dot product in the
// same cycle its last term is presented.
module mlp_mac #(
  parameter int A_W   = 25,
  parameter int B_W   = 11,
  parameter int ACC_W = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic signed [A_W-1:0]     a_i,
  input  logic signed [B_W-1:0]     b_i,
  output logic signed [A_W+B_W-1:0] prod_o,
  output logic signed [ACC_W-1:0]   sum_o
);
  localparam int P_W = A_W + B_W;

  logic signed [ACC_W-1:0] acc_q, acc_d;

  // Full-precision product, running sum and accumulator update.
  always_comb begin
    prod_o = P_W'(a_i) * P_W'(b_i);
    sum_o  = (clr_i ? '0 : acc_q) + ACC_W'(prod_o);
    acc_d  = en_i ? sum_o : acc_q;
  end

  // Accumulator register.
  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end
endmodule

// File: rtl/mlp_trainer.sv
// Single-hidden-layer ReLU perceptron with one shared MAC, host weight port
// and saturating output-layer training.
module mlp_trainer
  import mlp_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int N_HID    = N_HID_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int W_W      = W_W_DEF,
  parameter int H_W      = H_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int LR_SHIFT = LR_SHIFT_DEF
) (
  input logic          clk_i,
  input logic          rst_i,
  mlp_trainer_if.slave bus
);
  localparam int NW     = nw_of(N_IN, N_HID);
  localparam int V_BASE = vbase_of(N_IN, N_HID);
  localparam int AW     = $clog2(NW);
  localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW     = (N_HID > 1) ? $clog2(N_HID) : 1;
  // MAC operand A carries x, h or err; operand B carries a weight or h.
  localparam int A_W    = ACC_W + 1;
  localparam int B_W    = (W_W > H_W + 1) ? W_W : H_W + 1;
  localparam int P_W    = A_W + B_W;

  state_e                  state_q, state_d;
  logic [IW-1:0]           i_q, i_d;
  logic [JW-1:0]           j_q, j_d;
  logic [N_IN*X_W-1:0]     x_q, x_d;
  logic signed [ACC_W-1:0] target_q, target_d;
  logic                    train_q, train_d;
  logic signed [ACC_W-1:0] y_q, y_d;
  logic signed [ACC_W-1:0] err_q, err_d;
  logic signed [W_W-1:0]   rd_q, rd_d;
  logic [H_W-1:0]          h_q   [N_HID];
  logic [H_W-1:0]          h_d   [N_HID];
  logic signed [W_W-1:0]   wgt_q [NW];
  logic signed [W_W-1:0]   wgt_d [NW];
  logic signed [W_W-1:0]   wgt_def [NW];
  logic [X_W-1:0]          x_arr [N_IN];

  logic                    addr_ok;
  logic [AW-1:0]           hid_idx;
  logic [AW-1:0]           out_idx;
  logic signed [ACC_W-1:0] err_calc;
  wide_t                   upd_w;

  logic                    mac_clr, mac_en;
  logic signed [A_W-1:0]   mac_a;
  logic signed [B_W-1:0]   mac_b;
  logic signed [P_W-1:0]   mac_prod;
  logic signed [ACC_W-1:0] mac_sum;

  for (genvar gi = 0; gi < NW; gi++) begin : g_def
    assign wgt_def[gi] = (gi < V_BASE) ? W_W'(def_w(gi % N_IN)) : W_W'(def_v(gi - V_BASE));
  end

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
    assign x_arr[gi] = x_q[gi*X_W +: X_W];
  end

  assign addr_ok = {1'b0, bus.w_addr_i} < (AW+1)'(NW);
  assign hid_idx = AW'(int'(j_q) * N_IN + int'(i_q));
  assign out_idx = AW'(V_BASE + int'(j_q));

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.y_o         = y_q;
  assign bus.err_o       = err_q;
  assign bus.w_rd_data_o = rd_q;

  mlp_mac #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) u_mac (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .a_i    (mac_a),
    .b_i    (mac_b),
    .prod_o (mac_prod),
    .sum_o  (mac_sum)
  );

  // Route the operands for the current phase into the shared MAC.
  always_comb begin
    mac_a   = '0;
    mac_b   = '0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      S_FWD_HID: begin
        mac_a   = A_W'(x_arr[i_q]);
        mac_b   = B_W'(wgt_q[hid_idx]);
        mac_en  = 1'b1;
        mac_clr = (i_q == '0);
      end
      S_FWD_OUT: begin
        mac_a   = A_W'(h_q[j_q]);
        mac_b   = B_W'(wgt_q[out_idx]);
        mac_en  = 1'b1;
        mac_clr = (j_q == '0);
      end
      S_UPD: begin
        mac_a = A_W'(err_q);
        mac_b = B_W'(h_q[j_q]);
      end
      default: ;
    endcase
  end

  // Sequencer, host port and result/weight next-state logic.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    x_d      = x_q;
    target_d = target_q;
    train_d  = train_q;
    y_d      = y_q;
    err_d    = err_q;
    h_d      = h_q;
    wgt_d    = wgt_q;
    rd_d     = addr_ok ? wgt_q[bus.w_addr_i] : '0;
    // Difference is formed one bit wider than ACC_W, then clamped.
    err_calc = ACC_W'(sat_signed(wide_t'(target_q) - wide_t'(y_q), ACC_W));
    // Exact err*h product, arithmetic shift, then clamp to the weight range.
    upd_w    = sat_signed(wide_t'(wgt_q[out_idx]) + (wide_t'(mac_prod) >>> LR_SHIFT), W_W);

    case (state_q)
      S_IDLE: begin
        if (bus.w_wr_en_i && addr_ok) wgt_d[bus.w_addr_i] = bus.w_wr_data_i;
        if (bus.start_i) begin
          x_d      = bus.x_i;
          target_d = bus.target_i;
          train_d  = bus.train_i;
          i_d      = '0;
          j_d      = '0;
          state_d  = S_FWD_HID;
        end
      end
      S_FWD_HID: begin
        if (i_q == IW'(N_IN - 1)) begin
          h_d[j_q] = H_W'(relu_sat(wide_t'(mac_sum), H_W));
          i_d      = '0;
          if (j_q == JW'(N_HID - 1)) begin
            j_d     = '0;
            state_d = S_FWD_OUT;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_FWD_OUT: begin
        if (j_q == JW'(N_HID - 1)) begin
          y_d     = mac_sum;
          j_d     = '0;
          state_d = S_ERR;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_ERR: begin
        err_d   = err_calc;
        state_d = (train_q && (err_calc != '0)) ? S_UPD : S_DONE;
      end
      S_UPD: begin
        wgt_d[out_idx] = W_W'(upd_w);
        if (j_q == JW'(N_HID - 1)) begin
          j_d     = '0;
          state_d = S_DONE;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured pass inputs, results and weight array registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      x_q      <= '0;
      target_q <= '0;
      train_q  <= 1'b0;
      y_q      <= '0;
      err_q    <= '0;
      rd_q     <= '0;
      h_q      <= '{default: '0};
      wgt_q    <= wgt_def;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      x_q      <= x_d;
      target_q <= target_d;
      train_q  <= train_d;
      y_q      <= y_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      h_q      <= h_d;
      wgt_q    <= wgt_d;
    end
  end
endmodule

// File: tb/tb_mlp_trainer.sv
// Bench for mlp_trainer: directed table, corner sequences, randomized passes
// checked against an arithmetic reference model.
module tb_mlp_trainer;
  localparam int N_IN = 4, N_HID = 2, X_W = 4, W_W = 8, H_W = 10;
  localparam int ACC_W = 24, LR_SHIFT = 4;
  localparam int NW = N_HID * N_IN + N_HID;
  localparam int V_BASE = N_HID * N_IN;
  localparam int AW = $clog2(NW);
  localparam longint HMAX = (longint'(1) << H_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mlp_trainer_if #(.N_IN(N_IN), .N_HID(N_HID), .X_W(X_W), .W_W(W_W), .ACC_W(ACC_W)) ifc ();

  mlp_trainer #(
    .N_IN(N_IN), .N_HID(N_HID), .X_W(X_W), .W_W(W_W), .H_W(H_W),
    .ACC_W(ACC_W), .LR_SHIFT(LR_SHIFT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference weights, laid out by the public address map.
  int model_w [NW];

  typedef struct {
    logic [N_IN*X_W-1:0] x;
    logic [ACC_W-1:0]    tgt;
    bit                  trn;
    longint              y;
    longint              e;
    int                  lat;
  } vec_t;
  vec_t tbl [3];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint a, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    return (a > hi) ? hi : ((a < lo) ? lo : a);
  endfunction

  function automatic void model_reset();
    for (int a = 0; a < NW; a++)
      model_w[a] = (a < V_BASE) ? (a % N_IN) + 1 : (a - V_BASE) + 1;
  endfunction

  function automatic void model_write(input int a, input int d);
    logic [W_W-1:0] db;
    db = W_W'(d);
    if (a < NW) model_w[a] = int'($signed(db));
  endfunction

  function automatic longint model_read(input int a);
    return (a < NW) ? longint'(model_w[a]) : 0;
  endfunction

  // One forward pass plus optional update, in plain arithmetic.
  function automatic void model_pass(input logic [N_IN*X_W-1:0] x, input logic [ACC_W-1:0] tgt,
                                     input bit trn, output longint y, output longint e, output int lat);
    longint h [N_HID];
    longint acc;
    logic [N_IN*X_W-1:0] xs;
    logic [ACC_W-1:0] yt;
    for (int j = 0; j < N_HID; j++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) begin
        xs = x >> (i * X_W);
        acc += longint'(xs[X_W-1:0]) * longint'(model_w[j*N_IN + i]);
      end
      h[j] = (acc < 0) ? 0 : ((acc > HMAX) ? HMAX : acc);
    end
    y = 0;
    for (int j = 0; j < N_HID; j++) y += h[j] * longint'(model_w[V_BASE + j]);
    yt = y[ACC_W-1:0];
    y = longint'($signed(yt));
    e = sat(longint'($signed(tgt)) - y, ACC_W);
    lat = N_IN * N_HID + N_HID + 2;
    if (trn && e != 0) begin
      for (int j = 0; j < N_HID; j++)
        model_w[V_BASE + j] = int'(sat(longint'(model_w[V_BASE + j]) + ((e * h[j]) >>> LR_SHIFT), W_W));
      lat += N_HID;
    end
  endfunction

  task automatic write_w(input int a, input int d);
    @(negedge clk);
    ifc.w_wr_en_i   = 1'b1;
    ifc.w_addr_i    = AW'(a);
    ifc.w_wr_data_i = W_W'(d);
    @(negedge clk);
    ifc.w_wr_en_i   = 1'b0;
  endtask

  task automatic check_read(input int a, input string name);
    @(negedge clk);
    ifc.w_addr_i = AW'(a);
    @(negedge clk);
    check(name, longint'($signed(ifc.w_rd_data_o)), model_read(a));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Start a pass (optionally with a same-cycle write, optionally poking the
  // bus with a write and a start while busy) and measure its latency.
  task automatic do_pass(input logic [N_IN*X_W-1:0] x, input logic [ACC_W-1:0] tgt, input bit trn,
                         input bit wr, input int wa, input int wd, input bit poke,
                         output longint y, output longint e, output int lat);
    int c;
    @(negedge clk);
    ifc.start_i     = 1'b1;
    ifc.train_i     = trn;
    ifc.x_i         = x;
    ifc.target_i    = tgt;
    ifc.w_wr_en_i   = wr;
    ifc.w_addr_i    = AW'(wa);
    ifc.w_wr_data_i = W_W'(wd);
    @(negedge clk);
    ifc.start_i   = 1'b0;
    ifc.w_wr_en_i = 1'b0;
    check("busy_after_start", longint'(ifc.busy_o), 1);
    c = 1;
    while (!ifc.done_o && c < 40) begin
      ifc.start_i   = poke && (c == 3);
      ifc.w_wr_en_i = poke && (c == 3);
      if (poke && c == 3) begin
        ifc.w_addr_i    = AW'(V_BASE);
        ifc.w_wr_data_i = 8'h55;
        ifc.x_i         = '1;
      end
      @(negedge clk);
      c++;
    end
    ifc.start_i   = 1'b0;
    ifc.w_wr_en_i = 1'b0;
    lat = ifc.done_o ? c : -1;
    y = longint'($signed(ifc.y_o));
    e = longint'($signed(ifc.err_o));
    @(negedge clk);
    check("busy_after_done", longint'(ifc.busy_o), 0);
    check("done_one_cycle", longint'(ifc.done_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint y, e, ey, ee;
    int lat, elat, done_seen;
    logic [N_IN*X_W-1:0] rx;
    logic [ACC_W-1:0] rt;
    bit rtrn, cw;
    int wa, wd;

    ifc.start_i = 1'b0; ifc.train_i = 1'b0; ifc.x_i = '0; ifc.target_i = '0;
    ifc.w_wr_en_i = 1'b0; ifc.w_addr_i = '0; ifc.w_wr_data_i = '0;
    model_reset();

    tbl[0] = '{x: 16'h1111, tgt: 24'd30, trn: 1'b1, y: 30,  e: 0,    lat: 12};
    tbl[1] = '{x: 16'h1111, tgt: 24'd46, trn: 1'b1, y: 30,  e: 16,   lat: 14};
    tbl[2] = '{x: 16'h1111, tgt: 24'd0,  trn: 1'b0, y: 230, e: -230, lat: 12};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", longint'(ifc.busy_o), 0);
    check("rst_done", longint'(ifc.done_o), 0);
    check("rst_y", longint'(ifc.y_o), 0);
    check("rst_err", longint'(ifc.err_o), 0);
    check("rst_rd", longint'(ifc.w_rd_data_o), 0);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) check_read(a, "default_weight");

    // Directed table
    for (int t = 0; t < 3; t++) begin
      model_pass(tbl[t].x, tbl[t].tgt, tbl[t].trn, ey, ee, elat);
      do_pass(tbl[t].x, tbl[t].tgt, tbl[t].trn, 1'b0, 0, 0, 1'b0, y, e, lat);
      $display("table %0d: y=%0d err=%0d lat=%0d", t, y, e, lat);
      check("table_y", y, tbl[t].y);
      check("table_err", e, tbl[t].e);
      check("table_lat", longint'(lat), longint'(tbl[t].lat));
    end
    check_read(V_BASE, "trained_v0");
    check_read(V_BASE + 1, "trained_v1");
    check("trained_v0_const", longint'(model_w[V_BASE]), 11);

    // Negative hidden weights clamp h0 to zero
    reset_dut();
    for (int i = 0; i < N_IN; i++) begin
      write_w(i, 8'hFF);
      model_write(i, 8'hFF);
    end
    model_pass(16'h1111, 24'd0, 1'b0, ey, ee, elat);
    do_pass(16'h1111, 24'd0, 1'b0, 1'b0, 0, 0, 1'b0, y, e, lat);
    $display("relu: y=%0d err=%0d lat=%0d", y, e, lat);
    check("relu_y", y, 20);
    check("relu_lat", longint'(lat), 12);

    // Large error saturates both output weights
    reset_dut();
    model_pass(16'hFFFF, 24'h7FFFFF, 1'b1, ey, ee, elat);
    do_pass(16'hFFFF, 24'h7FFFFF, 1'b1, 1'b0, 0, 0, 1'b0, y, e, lat);
    $display("sat: y=%0d err=%0d lat=%0d", y, e, lat);
    check("sat_y", y, 450);
    check("sat_err", e, ee);
    check("sat_lat", longint'(lat), 14);
    check_read(V_BASE, "sat_v0");
    check_read(V_BASE + 1, "sat_v1");

    // Write and start while busy are ignored
    model_pass(16'h1111, 24'd0, 1'b0, ey, ee, elat);
    do_pass(16'h1111, 24'd0, 1'b0, 1'b0, 0, 0, 1'b1, y, e, lat);
    $display("busy poke: y=%0d err=%0d lat=%0d", y, e, lat);
    check("poke_y", y, ey);
    check("poke_lat", longint'(lat), longint'(elat));
    check_read(V_BASE, "poke_v0");
    check_read(V_BASE + 1, "poke_v1");
    check_read(NW, "oob_read");

    // Reset in the middle of FWD_HID
    @(negedge clk);
    ifc.start_i = 1'b1; ifc.train_i = 1'b1; ifc.x_i = 16'h1111; ifc.target_i = 24'd99;
    @(negedge clk);
    ifc.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", longint'(ifc.busy_o), 0);
    rst = 1'b0;
    model_reset();
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifc.done_o) done_seen++;
    end
    check("midrst_no_done", longint'(done_seen), 0);
    for (int a = 0; a < NW; a++) check_read(a, "midrst_default");

    // Randomized passes against the reference model
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        wa = int'($urandom_range(0, 15));
        wd = int'($urandom_range(0, 255));
        write_w(wa, wd);
        model_write(wa, wd);
      end
      rx = N_IN*X_W'($urandom);
      case ($urandom_range(0, 2))
        0:       rt = ACC_W'($urandom);
        1:       rt = ACC_W'($urandom_range(0, 600));
        default: rt = ($urandom_range(0, 1) == 1) ? 24'h7FFFFF : 24'h800000;
      endcase
      rtrn = ($urandom_range(0, 1) == 1);
      cw   = ($urandom_range(0, 3) == 0);
      wa   = int'($urandom_range(0, NW - 1));
      wd   = int'($urandom_range(0, 255));
      if (cw) model_write(wa, wd);
      model_pass(rx, rt, rtrn, ey, ee, elat);
      do_pass(rx, rt, rtrn, cw, wa, wd, 1'b0, y, e, lat);
      $display("rand %0d: x=%h tgt=%h train=%0d wr=%0d y=%0d err=%0d lat=%0d", t, rx, rt, rtrn, cw, y, e, lat);
      check("rand_y", y, ey);
      check("rand_err", e, ee);
      check("rand_lat", longint'(lat), longint'(elat));
    end
    for (int a = 0; a < 16; a++) check_read(a, "final_weight");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
